// File: rtl/bcd_updown_timer.sv
// Minutes/seconds BCD up/down timer with adjust, preset load and terminal-event pulses.
// Optional lap/snapshot display is enabled by defining BCD_TIMER_LAP_EN.
module bcd_updown_timer #(
  parameter int MIN_DIGITS   = 2,
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick_1hz,
  input  logic                          tick_2hz,
  input  logic                          start_stop,
  input  logic                          dir,
  input  logic                          adj,
  input  logic                          sel,
  input  logic                          load,
  input  logic [4*(MIN_DIGITS+2)-1:0]   load_value,
`ifdef BCD_TIMER_LAP_EN
  input  logic                          lap,
  output logic                          lap_active,
`endif
  output logic [4*(MIN_DIGITS+2)-1:0]   digits,
  output logic                          running,
  output logic                          wrap,
  output logic                          expired
);

  localparam int ND = MIN_DIGITS + 2;
  localparam int W  = 4 * ND;

  typedef enum logic [1:0] {STOPPED, RUNNING, EXPIRED} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   count, count_nxt;
  logic           wrap_nxt, expired_nxt;
  logic [W:0]     inc_r;
  logic [W-1:0]   dec_r;

  // Digit 1 is the seconds tens digit (0..5); every other digit is 0..9.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 1) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (c) begin
        if (r[4*i +: 4] >= digit_max(i)) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (b) begin
        if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = digit_max(i);
        else begin
          r[4*i +: 4] = r[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Adjust increments one field only; carries never cross between seconds and minutes.
  function automatic logic [W-1:0] adj_step(input logic [W-1:0] v, input logic sec_field);
    logic [W-1:0] r;
    logic         c;
    r = v;
    if (sec_field) begin
      if (r[3:0] >= 4'd9) begin
        r[3:0] = 4'd0;
        r[7:4] = (r[7:4] >= 4'd5) ? 4'd0 : r[7:4] + 4'd1;
      end else begin
        r[3:0] = r[3:0] + 4'd1;
      end
    end else begin
      c = 1'b1;
      for (int i = 2; i < ND; i++) begin
        if (c) begin
          if (r[4*i +: 4] >= 4'd9) r[4*i +: 4] = 4'd0;
          else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++)
      if (r[4*i +: 4] > digit_max(i)) r[4*i +: 4] = digit_max(i);
    return r;
  endfunction

  assign inc_r = bcd_inc(count);
  assign dec_r = bcd_dec(count);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= STOPPED;
      count   <= '0;
      wrap    <= 1'b0;
      expired <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      wrap    <= wrap_nxt;
      expired <= expired_nxt;
    end
  end

  // Steps are taken from the pre-toggle state; start_stop only decides the next state.
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    wrap_nxt    = 1'b0;
    expired_nxt = 1'b0;
    if (load) begin
      count_nxt = clamp(load_value);
      state_nxt = STOPPED;
    end else if (adj) begin
      state_nxt = STOPPED;
      if (tick_2hz) count_nxt = adj_step(count, sel);
    end else begin
      if (state == RUNNING && tick_1hz) begin
        if (dir) begin
          count_nxt = inc_r[W-1:0];
          wrap_nxt  = inc_r[W];
        end else if (count == '0) begin
          if (STOP_AT_ZERO) begin
            state_nxt   = EXPIRED;
            expired_nxt = 1'b1;
          end else begin
            count_nxt = dec_r;
            wrap_nxt  = 1'b1;
          end
        end else begin
          count_nxt = dec_r;
          if (dec_r == '0 && STOP_AT_ZERO) begin
            state_nxt   = EXPIRED;
            expired_nxt = 1'b1;
          end
        end
      end
      if (start_stop) begin
        case (state)
          STOPPED: if (dir || count != '0 || !STOP_AT_ZERO) state_nxt = RUNNING;
          RUNNING: state_nxt = STOPPED;
          EXPIRED: state_nxt = STOPPED;
          default: state_nxt = STOPPED;
        endcase
      end
      if (state_nxt != EXPIRED) expired_nxt = 1'b0;
    end
  end

  assign running = (state == RUNNING);

`ifdef BCD_TIMER_LAP_EN
  logic [W-1:0] snapshot;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_active <= 1'b0;
      snapshot   <= '0;
    end else if (load) begin
      lap_active <= 1'b0;
    end else if (lap) begin
      lap_active <= ~lap_active;
      snapshot   <= count;
    end
  end

  assign digits = lap_active ? snapshot : count;
`else
  assign digits = count;
`endif

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Self-checking bench for bcd_updown_timer (MIN_DIGITS=2): directed vector table,
// hand-written corner sequences and randomized traffic against a seconds-count model.
module tb_bcd_updown_timer;

  localparam int MD   = 2;
  localparam int W    = 4 * (MD + 2);
  localparam int MAXV = 99 * 60 + 59;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         tick_1hz, tick_2hz, start_stop, dir, adj, sel, load;
  logic [W-1:0] load_value;
  logic [W-1:0] digits, digits2;
  logic         running, wrap, expired;
  logic         running2, wrap2, expired2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_updown_timer #(.MIN_DIGITS(MD), .STOP_AT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .start_stop(start_stop), .dir(dir), .adj(adj), .sel(sel), .load(load),
    .load_value(load_value), .digits(digits), .running(running),
    .wrap(wrap), .expired(expired)
  );

  bcd_updown_timer #(.MIN_DIGITS(MD), .STOP_AT_ZERO(1'b0)) dut_wrap (
    .clk(clk), .rst(rst_n), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .start_stop(start_stop), .dir(dir), .adj(adj), .sel(sel), .load(load),
    .load_value(load_value), .digits(digits2), .running(running2),
    .wrap(wrap2), .expired(expired2)
  );

  typedef struct {
    logic [6:0]   ctl;
    logic [W-1:0] lv;
    logic [W-1:0] e_dig;
    logic [2:0]   e_out;
  } vec_t;

  vec_t vecs[$];

  // ctl = {load, start_stop, dir, tick_1hz, tick_2hz, adj, sel}; e_out = {running, wrap, expired}
  function automatic vec_t mk(input logic [6:0] c, input logic [W-1:0] lv,
                              input logic [W-1:0] ed, input logic [2:0] eo);
    vec_t v;
    v.ctl = c; v.lv = lv; v.e_dig = ed; v.e_out = eo;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] c, input logic [W-1:0] lv);
    {load, start_stop, dir, tick_1hz, tick_2hz, adj, sel} = c;
    load_value = lv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {load, start_stop, dir, tick_1hz, tick_2hz, adj, sel} = '0;
    load_value = '0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Behavioural reference: the count is a plain number of seconds.
  localparam int M_STOP = 0, M_RUN = 1, M_EXP = 2;
  int m_val, m_state;
  bit m_wrap, m_exp;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int s, m;
    s = v % 60;
    m = v / 60;
    r[3:0] = 4'(s % 10);
    r[7:4] = 4'(s / 10);
    for (int i = 0; i < MD; i++) begin
      r[8+4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [W-1:0] lv);
    logic [W-1:0] t;
    int d, sec, mn, scale;
    t = lv;
    sec = 0; mn = 0; scale = 1;
    d = int'(t[3:0]); if (d > 9) d = 9; sec += d;
    d = int'(t[7:4]); if (d > 5) d = 5; sec += 10 * d;
    for (int i = 0; i < MD; i++) begin
      d = int'(t[8+4*i +: 4]);
      if (d > 9) d = 9;
      mn += scale * d;
      scale *= 10;
    end
    return mn * 60 + sec;
  endfunction

  task automatic model_step(input logic ld, input logic [W-1:0] lv, input logic ss, input logic dr,
                            input logic t1, input logic t2, input logic ad, input logic sl);
    int nstate, old_val;
    m_wrap = 0;
    m_exp  = 0;
    old_val = m_val;
    if (ld) begin
      m_val = from_load(lv);
      m_state = M_STOP;
    end else if (ad) begin
      m_state = M_STOP;
      if (t2) begin
        if (sl) m_val = (m_val / 60) * 60 + ((m_val % 60) + 1) % 60;
        else    m_val = (((m_val / 60) + 1) % 100) * 60 + (m_val % 60);
      end
    end else begin
      nstate = m_state;
      if (m_state == M_RUN && t1) begin
        if (dr) begin
          if (m_val == MAXV) begin m_val = 0; m_wrap = 1; end
          else m_val++;
        end else if (m_val == 0) begin
          nstate = M_EXP; m_exp = 1;
        end else begin
          m_val--;
          if (m_val == 0) begin nstate = M_EXP; m_exp = 1; end
        end
      end
      if (ss) begin
        if (m_state == M_STOP) begin
          if (!(dr == 0 && old_val == 0)) nstate = M_RUN;
        end else nstate = M_STOP;
      end
      if (nstate != M_EXP) m_exp = 0;
      m_state = nstate;
    end
  endtask

  initial begin
    do_reset();
    check_output("reset digits", 32'(digits), 32'h0);
    check_output("reset running", 32'(running), 32'h0);
    check_output("reset wrap", 32'(wrap), 32'h0);
    check_output("reset expired", 32'(expired), 32'h0);

    // 61 up ticks from reset reads 01:01
    apply_stimulus(7'b0110000, '0);
    for (int i = 0; i < 61; i++) apply_stimulus(7'b0011000, '0);
    check_output("61 ticks digits", 32'(digits), 32'h0101);
    check_output("61 ticks running", 32'(running), 32'h1);

    vecs.push_back(mk(7'b1000000, 16'h7F9A, 16'h7959, 3'b000));
    vecs.push_back(mk(7'b0000111, 16'h0000, 16'h7900, 3'b000));
    vecs.push_back(mk(7'b0000110, 16'h0000, 16'h8000, 3'b000));
    vecs.push_back(mk(7'b1000000, 16'h9900, 16'h9900, 3'b000));
    vecs.push_back(mk(7'b0000110, 16'h0000, 16'h0000, 3'b000));
    vecs.push_back(mk(7'b1000000, 16'h0059, 16'h0059, 3'b000));
    vecs.push_back(mk(7'b0000111, 16'h0000, 16'h0000, 3'b000));
    vecs.push_back(mk(7'b1000000, 16'h9959, 16'h9959, 3'b000));
    vecs.push_back(mk(7'b0110000, 16'h0000, 16'h9959, 3'b100));
    vecs.push_back(mk(7'b0011000, 16'h0000, 16'h0000, 3'b110));
    vecs.push_back(mk(7'b0010000, 16'h0000, 16'h0000, 3'b100));
    vecs.push_back(mk(7'b1000000, 16'h0002, 16'h0002, 3'b000));
    vecs.push_back(mk(7'b0100000, 16'h0000, 16'h0002, 3'b100));
    vecs.push_back(mk(7'b0001000, 16'h0000, 16'h0001, 3'b100));
    vecs.push_back(mk(7'b0001000, 16'h0000, 16'h0000, 3'b001));
    vecs.push_back(mk(7'b0001000, 16'h0000, 16'h0000, 3'b000));
    vecs.push_back(mk(7'b0100000, 16'h0000, 16'h0000, 3'b000));
    vecs.push_back(mk(7'b0100000, 16'h0000, 16'h0000, 3'b000));
    vecs.push_back(mk(7'b0110000, 16'h0000, 16'h0000, 3'b100));
    vecs.push_back(mk(7'b0111000, 16'h0000, 16'h0001, 3'b000));
    vecs.push_back(mk(7'b1100000, 16'h1234, 16'h1234, 3'b000));
    vecs.push_back(mk(7'b0110000, 16'h0000, 16'h1234, 3'b100));
    vecs.push_back(mk(7'b0011111, 16'h0000, 16'h1235, 3'b000));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].ctl, vecs[i].lv);
      check_output($sformatf("vec%0d digits", i), 32'(digits), 32'(vecs[i].e_dig));
      check_output($sformatf("vec%0d running", i), 32'(running), 32'(vecs[i].e_out[2]));
      check_output($sformatf("vec%0d wrap", i), 32'(wrap), 32'(vecs[i].e_out[1]));
      check_output($sformatf("vec%0d expired", i), 32'(expired), 32'(vecs[i].e_out[0]));
    end

    // Without stop-at-zero, a down step from 00:00 wraps to 99:59
    apply_stimulus(7'b1000000, 16'h0000);
    apply_stimulus(7'b0100000, 16'h0000);
    check_output("nostop running", 32'(running2), 32'h1);
    check_output("stop ignores start at zero", 32'(running), 32'h0);
    apply_stimulus(7'b0001000, 16'h0000);
    check_output("nostop wrap digits", 32'(digits2), 32'h9959);
    check_output("nostop wrap pulse", 32'(wrap2), 32'h1);
    check_output("nostop no expired", 32'(expired2), 32'h0);
    apply_stimulus(7'b0000000, 16'h0000);
    check_output("nostop wrap clears", 32'(wrap2), 32'h0);

    // Randomized traffic against the model
    do_reset();
    m_val = 0; m_state = M_STOP; m_wrap = 0; m_exp = 0;
    for (int n = 0; n < 800; n++) begin
      logic ld, ss, dr, t1, t2, ad, sl;
      logic [W-1:0] lv;
      ld = ($urandom_range(24) == 0);
      ss = ($urandom_range(5) == 0);
      dr = ($urandom_range(3) != 0) ? 1'b0 : 1'b1;
      t1 = ($urandom_range(2) == 0);
      t2 = ($urandom_range(2) == 0);
      ad = ($urandom_range(9) == 0);
      sl = $urandom_range(1) == 1;
      lv = (n % 3 == 0) ? W'($urandom) : to_bcd(int'($urandom_range(12)));
      model_step(ld, lv, ss, dr, t1, t2, ad, sl);
      apply_stimulus({ld, ss, dr, t1, t2, ad, sl}, lv);
      check_output($sformatf("rnd%0d digits", n), 32'(digits), 32'(to_bcd(m_val)));
      check_output($sformatf("rnd%0d running", n), 32'(running), 32'(m_state == M_RUN));
      check_output($sformatf("rnd%0d wrap", n), 32'(wrap), 32'(m_wrap));
      check_output($sformatf("rnd%0d expired", n), 32'(expired), 32'(m_exp));
    end

    // Asynchronous reset in the middle of a running cycle
    apply_stimulus(7'b1000000, 16'h4321);
    apply_stimulus(7'b0110000, 16'h0000);
    {load, start_stop, dir, tick_1hz, tick_2hz, adj, sel} = 7'b0011000;
    #3;
    rst_n = 1'b0;
    #1;
    check_output("async reset digits", 32'(digits), 32'h0);
    check_output("async reset running", 32'(running), 32'h0);
    @(posedge clk);
    #1;
    check_output("held reset wrap", 32'(wrap), 32'h0);
    check_output("held reset digits", 32'(digits), 32'h0);
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
